// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder/subtractor around one full_adder cell
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] s_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_d;

    full_adder u_fa (
        .a    (op_a_q[0]),
        .b    (op_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign sum_d = {fa_s, sum_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                        op_a_q  <= a;
                        op_b_q  <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    op_a_q  <= op_a_q >> 1;
                    op_b_q  <= op_b_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= fa_cout;
                    if (cnt_q == LAST) begin
                        // MSB bit: carry_q is the carry into the sign position.
                        s_q     <= sum_d;
                        cout_q  <= fa_cout;
                        ovf_q   <= carry_q ^ fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign s        = s_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder with arithmetic reference model
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         overflow;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           issue;
    } exp_t;

    exp_t q[$];

    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic sb, int issue);
        exp_t e;
        int ua, ub, sx, sy, ur, sr;
        ua = int'(x);
        ub = int'(y);
        sx = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
        sy = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
        ur = sb ? ua - ub : ua + ub;
        sr = sb ? sx - sy : sx + sy;
        e.s     = W'(ur);
        e.c     = sb ? (ua >= ub) : (ur >= 2 ** W);
        e.v     = (sr < -(2 ** (W - 1))) || (sr > 2 ** (W - 1) - 1);
        e.issue = issue;
        return e;
    endfunction

    int   busy_cnt = 0;
    exp_t me;
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done got s=%h cout=%0b ovf=%0b", s, cout, overflow);
                end else begin
                    me = q.pop_front();
                    if ({s, cout, overflow} !== {me.s, me.c, me.v}) begin
                        fails++;
                        $display("FAIL result got s=%h cout=%0b ovf=%0b exp s=%h cout=%0b ovf=%0b",
                                 s, cout, overflow, me.s, me.c, me.v);
                    end
                    tests++;
                    if (cyc - me.issue != W) begin
                        fails++;
                        $display("FAIL latency got %0d exp %0d", cyc - me.issue, W);
                    end
                    tests++;
                    if (busy_cnt != W || busy !== 1'b0) begin
                        fails++;
                        $display("FAIL busy_len got %0d (busy=%0b) exp %0d (busy=0)", busy_cnt, busy, W);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL wait_idle timeout got busy=%0b exp 0", busy);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL wait_done timeout got done=0 exp 1");
        end
    endtask

    task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic sb, bit push);
        a     = x;
        b     = y;
        sub   = sb;
        start = 1'b1;
        if (push) q.push_back(model(x, y, sb, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic run_op(logic [W-1:0] x, logic [W-1:0] y, logic sb);
        wait_idle();
        issue(x, y, sb, 1'b1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, s, cout, overflow} !== '0) begin
            fails++;
            $display("FAIL reset_state got busy=%0b done=%0b s=%h cout=%0b ovf=%0b exp all 0",
                     busy, done, s, cout, overflow);
        end
        reset = 1'b0;
        @(negedge clk);

        run_op(8'h3C, 8'h25, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h05, 8'h07, 1'b1);
        run_op(8'h80, 8'h01, 1'b1);

        // start pulsed mid-RUN must not disturb the operation
        run_op(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        sub   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // abort with reset in the 4th RUN cycle
        wait_idle();
        issue(8'h11, 8'h22, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, done, s, cout, overflow} !== '0) begin
            fails++;
            $display("FAIL abort_state got busy=%0b done=%0b s=%h cout=%0b ovf=%0b exp all 0",
                     busy, done, s, cout, overflow);
        end
        reset = 1'b0;
        repeat (12) @(negedge clk);
        run_op(8'hC8, 8'h64, 1'b0);

        // back-to-back: start held in the DONE cycle
        wait_idle();
        issue(8'h40, 8'h40, 1'b0, 1'b1);
        wait_done();
        issue(8'h9C, 8'h33, 1'b1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 1) begin
                wait_done();
                issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            end else begin
                run_op(W'($urandom), W'($urandom), 1'($urandom));
            end
        end

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
